// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes, flag bit positions
// and FSM states.
package alu_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam logic [3:0]  ALU_OP_SEL_DEF = 4'b0001;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_SRA = 4'h9;
  localparam logic [3:0] OP_ADC = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MULB = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Serial shift-add multiplier: one multiplier bit per cycle after start.
// done_c/product_c are combinational so the final partial sum is usable on the last edge.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      done_c,
  output logic [2*DATA_WIDTH-1:0]   product_c
);

  localparam int unsigned P_W   = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic                  busy_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [P_W-1:0]        mcand_q;
  logic [P_W-1:0]        acc_q;
  logic [DATA_WIDTH-1:0] mplier_q;

  assign product_c = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_c    = busy_q && (cnt_q == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= P_W'(a);
      acc_q    <= '0;
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= product_c;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done_c) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; single-cycle ops plus a serial
// multiplier. Result and V/N/C/Z flags are held until the consumer drains them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [3:0]  ALU_OP_SEL = ALU_OP_SEL_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           opcode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] c,
  output logic [3:0]            flags
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned SH_W = $clog2(DATA_WIDTH);

  alu_state_e     state_q, state_d;
  logic [W-1:0]   c_q, c_d;
  logic [3:0]     flags_q, flags_d;
  logic           out_valid_q, out_valid_d;

  logic [3:0]     sel, op;
  logic           is_alu, is_mul, accept, mul_start, mul_done_c;
  logic [2*W-1:0] mul_prod_c;
  logic           unused_opcode_low;

  assign sel               = opcode[15:12];
  assign op                = opcode[11:8];
  assign unused_opcode_low = ^opcode[7:0];
  assign is_alu            = (sel == ALU_OP_SEL);
  assign is_mul            = is_alu && (op == OP_MUL);

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign flags     = flags_q;

  // Single-cycle datapath at W+1 bits; fres is the value Z/N are taken from (differs from res for CMP).
  logic [W:0]      sum_w, dif_w, shl_w, shr_w, sra_w;
  logic [SH_W-1:0] sh;
  logic [W-1:0]    res, fres;
  logic            cy, ov, upd, cin;
  logic [3:0]      alu_flg;

  always_comb begin
    sh    = b[SH_W-1:0];
    cin   = (op == OP_ADC) ? flags_q[FLAG_C] : 1'b0;
    sum_w = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
    dif_w = {1'b0, a} - {1'b0, b};
    shl_w = {1'b0, a} << sh;
    shr_w = {a, 1'b0} >> sh;
    sra_w = $unsigned($signed({a, 1'b0}) >>> sh);
    res   = '0;
    fres  = '0;
    cy    = 1'b0;
    ov    = 1'b0;
    upd   = 1'b0;
    if (is_alu) begin
      upd = 1'b1;
      case (op)
        OP_ADD, OP_ADC: begin
          res = sum_w[W-1:0];
          cy  = sum_w[W];
          ov  = (a[W-1] == b[W-1]) && (sum_w[W-1] != a[W-1]);
        end
        OP_SUB, OP_CMP: begin
          res = (op == OP_CMP) ? a : dif_w[W-1:0];
          cy  = dif_w[W];
          ov  = (a[W-1] != b[W-1]) && (dif_w[W-1] != a[W-1]);
        end
        OP_AND: res = a & b;
        OP_OR:  res = a | b;
        OP_XOR: res = a ^ b;
        OP_NOT: res = ~a;
        OP_SHL: begin
          res = shl_w[W-1:0];
          cy  = shl_w[W];
        end
        OP_SHR: begin
          res = shr_w[W:1];
          cy  = shr_w[0];
        end
        OP_SRA: begin
          res = sra_w[W:1];
          cy  = sra_w[0];
        end
        default: upd = 1'b0;
      endcase
    end
    fres    = (is_alu && op == OP_CMP) ? dif_w[W-1:0] : res;
    alu_flg = upd ? {ov, fres[W-1], cy, ~|fres} : flags_q;
  end

  alu_seq_mul #(.DATA_WIDTH(W)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (mul_start),
    .a         (a),
    .b         (b),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    mul_start   = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d   = MULB;
            mul_start = 1'b1;
          end else begin
            c_d         = res;
            flags_d     = alu_flg;
            out_valid_d = 1'b1;
          end
        end
      end
      MULB: begin
        if (mul_done_c) begin
          state_d     = IDLE;
          c_d         = mul_prod_c[W-1:0];
          flags_d     = {1'b0, mul_prod_c[W-1], |mul_prod_c[2*W-1:W], ~|mul_prod_c[W-1:0]};
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      c_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed results, flags, handshake timing
// and reset during a multiply.
module tb_alu_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic [3:0]   flags;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0]  op;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] cx;
    logic [3:0]   fx;
  } vec_t;

  vec_t tbl[9];

  alu_seq #(.DATA_WIDTH(W), .ALU_OP_SEL(4'b0001)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = 1'b1;
    opcode   = op;
    a        = av;
    b        = bv;
  endtask

  initial begin
    int  n;
    bit  bad;
    bit  seen;

    tbl[0] = '{16'h1600, 16'h8001, 16'h0001, 16'h0002, 4'b0010}; // SHL, carry = old MSB
    tbl[1] = '{16'h1700, 16'h0003, 16'h0001, 16'h0001, 4'b0010}; // SHR
    tbl[2] = '{16'h1900, 16'h8000, 16'h0004, 16'hF800, 4'b0100}; // SRA
    tbl[3] = '{16'h1600, 16'h8001, 16'h0010, 16'h8001, 4'b0100}; // shift 0, upper b ignored
    tbl[4] = '{16'h1B00, 16'h0005, 16'h0005, 16'h0005, 4'b0001}; // CMP equal
    tbl[5] = '{16'h1200, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100}; // AND
    tbl[6] = '{16'h1300, 16'h0000, 16'h0000, 16'h0000, 4'b0001}; // OR zero
    tbl[7] = '{16'h1500, 16'hFFFF, 16'h0000, 16'h0000, 4'b0001}; // NOT
    tbl[8] = '{16'h1000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100}; // ADD signed overflow

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = '0;
    a         = '0;
    b         = '0;
    tick;
    tick;
    chk("rst_c", c, 0);
    chk("rst_flags", flags, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    tick;

    // ADD with carry out and zero result
    issue(16'h1000, 16'hFFFF, 16'h0001);
    #1;
    chk("add_in_ready", in_ready, 1);
    chk("add_pre_valid", out_valid, 0);
    tick;
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_c", c, 16'h0000);
    chk("add_flags", flags, 4'b0011);
    tick;
    chk("add_drain", out_valid, 0);
    chk("add_flags_hold", flags, 4'b0011);

    // SUB with borrow, then back-to-back ADC consuming that carry
    issue(16'h1100, 16'h0003, 16'h0005);
    tick;
    chk("sub_c", c, 16'hFFFE);
    chk("sub_flags", flags, 4'b0110);
    issue(16'h1A00, 16'h0001, 16'h0001);
    tick;
    in_valid = 1'b0;
    chk("adc_c", c, 16'h0003);
    chk("adc_flags", flags, 4'b0000);
    tick;

    // MUL latency and in_ready low during MULB
    issue(16'h1800, 16'h0100, 16'h0100);
    tick;
    in_valid = 1'b0;
    n   = 0;
    bad = 1'b0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (in_ready !== 1'b0) bad = 1'b1;
      tick;
      n++;
    end
    chk("mul_latency", n, 16);
    chk("mul_in_ready_low", bad, 0);
    chk("mul_c", c, 16'h0000);
    chk("mul_flags", flags, 4'b0011);
    tick;

    // Backpressure: result holds, no acceptance while undrained
    out_ready = 1'b0;
    issue(16'h1000, 16'h1200, 16'h0034);
    tick;
    in_valid = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      if (c !== 16'h1234 || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
      tick;
    end
    chk("hold_stable", bad, 0);
    chk("hold_c", c, 16'h1234);
    out_ready = 1'b1;
    issue(16'h1400, 16'hFF00, 16'h0FF0);
    #1;
    chk("drain_in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("xor_valid", out_valid, 1);
    chk("xor_c", c, 16'hF0F0);
    chk("xor_flags", flags, 4'b0100);
    tick;
    chk("xor_drain", out_valid, 0);
    chk("xor_hold_c", c, 16'hF0F0);

    // Non-ALU select and illegal operation leave flags alone
    issue(16'h1000, 16'hFFFF, 16'h0001);
    tick;
    chk("pre_flags", flags, 4'b0011);
    issue(16'h2000, 16'h1234, 16'h0001);
    tick;
    chk("nonalu_valid", out_valid, 1);
    chk("nonalu_c", c, 16'h0000);
    chk("nonalu_flags", flags, 4'b0011);
    issue(16'h1D00, 16'h0005, 16'h0005);
    tick;
    chk("illegal_c", c, 16'h0000);
    chk("illegal_flags", flags, 4'b0011);

    // Shift, compare, logic and overflow vectors back to back
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].av, tbl[i].bv);
      tick;
      chk($sformatf("tbl%0d_c", i), c, tbl[i].cx);
      chk($sformatf("tbl%0d_flags", i), flags, tbl[i].fx);
    end
    in_valid = 1'b0;

    // Reset in the middle of a multiply
    issue(16'h1800, 16'h0003, 16'h0005);
    tick;
    in_valid = 1'b0;
    chk("mulrst_started", in_ready, 0);
    repeat (4) tick;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mulrst_c", c, 0);
    chk("mulrst_flags", flags, 0);
    chk("mulrst_out_valid", out_valid, 0);
    chk("mulrst_in_ready", in_ready, 1);
    tick;
    reset_n = 1'b1;
    tick;
    chk("mulrst_release_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (24) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick;
    end
    chk("mulrst_no_stale", seen, 0);
    chk("mulrst_c_after", c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
